// File: rtl/matrix_result_serializer.sv
// Captures a DIM1 x DIM0 accumulator tile, requantizes each element and streams it one row per beat.
// Optional round-half-up before the shift is enabled by defining MATRIX_SERIALIZER_ROUND_EN.
module matrix_result_serializer #(
  parameter int IN_WIDTH   = 34,
  parameter int OUT_WIDTH  = 8,
  parameter int FRAC_SHIFT = 4,
  parameter int DIM0       = 2,
  parameter int DIM1       = 2,
  localparam int ROW_W     = (DIM1 > 1) ? $clog2(DIM1) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DIM0*DIM1*IN_WIDTH-1:0]  in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DIM0*OUT_WIDTH-1:0]      out_data,
  output logic [ROW_W-1:0]               out_row,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

`ifdef MATRIX_SERIALIZER_ROUND_EN
  localparam int BIAS_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [IN_WIDTH:0] BIAS =
    (FRAC_SHIFT > 0) ? ((IN_WIDTH+1)'(1) << BIAS_POS) : '0;

  function automatic logic signed [IN_WIDTH:0] round_bias(input logic signed [IN_WIDTH:0] t);
    return t + BIAS;
  endfunction
`endif

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [IN_WIDTH:0] s);
    logic signed [IN_WIDTH:0] c;
    if (s > SAT_MAX)      c = SAT_MAX;
    else if (s < SAT_MIN) c = SAT_MIN;
    else                  c = s;
    return c[OUT_WIDTH-1:0];
  endfunction

  // One extra bit of headroom keeps the rounding add from wrapping near the positive limit
  function automatic logic signed [OUT_WIDTH-1:0] quant(input logic signed [IN_WIDTH-1:0] x);
    logic signed [IN_WIDTH:0] t;
    logic signed [IN_WIDTH:0] s;
    t = {x[IN_WIDTH-1], x};
`ifdef MATRIX_SERIALIZER_ROUND_EN
    t = round_bias(t);
`endif
    s = t >>> FRAC_SHIFT;
    return saturate(s);
  endfunction

  state_t                          r_state;
  logic [ROW_W-1:0]                r_row;
  logic [DIM0*DIM1*IN_WIDTH-1:0]   r_tile;
  logic                            r_valid;
  logic                            r_last;
  logic                            w_last_row;
  logic [ROW_W-1:0]                w_row_inc;

  assign w_last_row = (r_row == ROW_W'(DIM1 - 1));
  assign w_row_inc  = r_row + ROW_W'(1);
  assign in_ready   = (r_state == S_IDLE) || ((r_state == S_EMIT) && w_last_row && out_ready);

  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign out_row    = r_row;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_tile  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_tile  <= in_data;
            r_row   <= '0;
            r_last  <= (DIM1 == 1);
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (!w_last_row) begin
              r_row  <= w_row_inc;
              r_last <= (w_row_inc == ROW_W'(DIM1 - 1));
            end else if (in_valid) begin
              // Chain the next tile straight onto the last beat so the stream has no bubble
              r_tile <= in_data;
              r_row  <= '0;
              r_last <= (DIM1 == 1);
            end else begin
              r_row   <= '0;
              r_last  <= 1'b0;
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: requantize the selected row straight from the tile register
  always_comb begin
    out_data = '0;
    for (int j = 0; j < DIM0; j++) begin
      out_data[j*OUT_WIDTH +: OUT_WIDTH] =
        quant(r_tile[(int'(r_row)*DIM0 + j)*IN_WIDTH +: IN_WIDTH]);
    end
  end

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: queue-based row model checked every cycle plus literal checks.
module tb_matrix_result_serializer;

  localparam int IW = 34;
  localparam int OW = 8;
  localparam int FS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [4*IW-1:0]    in_data;
  logic               in_valid;
  logic               in_ready;
  logic [2*OW-1:0]    out_data;
  logic [0:0]         out_row;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic [0:0]  row;
    logic        last;
  } row_t;

  row_t q[$];

  matrix_result_serializer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAC_SHIFT(FS), .DIM0(2), .DIM1(2)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_row(out_row), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Requantization straight from the arithmetic definition
  function automatic int mq(input longint x);
    longint t;
    longint s;
    t = x;
`ifdef MATRIX_SERIALIZER_ROUND_EN
    if (FS > 0) t = t + (longint'(1) << (FS - 1));
`endif
    s = t >>> FS;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  function automatic logic [15:0] pack2(input int a, input int b);
    return {b[7:0], a[7:0]};
  endfunction

  function automatic logic [4*IW-1:0] pack4(input longint a, input longint b,
                                            input longint c, input longint d);
    logic [4*IW-1:0] r;
    r = '0;
    r[0*IW +: IW] = a[IW-1:0];
    r[1*IW +: IW] = b[IW-1:0];
    r[2*IW +: IW] = c[IW-1:0];
    r[3*IW +: IW] = d[IW-1:0];
    return r;
  endfunction

  function automatic longint elem(input logic [4*IW-1:0] d, input int k);
    logic signed [IW-1:0] e;
    e = d[k*IW +: IW];
    return longint'(e);
  endfunction

  // Cycle-by-cycle comparison against the row queue
  always @(negedge clk) begin
    logic m_rdy;
    row_t r;
    if (!rst) begin
      q.delete();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_last",  {63'd0, out_last},  64'd0);
      chk("rst_out_row",   {63'd0, out_row},   64'd0);
      chk("rst_out_data",  {48'd0, out_data},  64'd0);
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    end else begin
      m_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("in_ready",  {63'd0, in_ready},  {63'd0, m_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("out_data", {48'd0, out_data}, {48'd0, q[0].data});
        chk("out_row",  {63'd0, out_row},  {63'd0, q[0].row});
        chk("out_last", {63'd0, out_last}, {63'd0, q[0].last});
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && m_rdy) begin
        for (int i = 0; i < 2; i++) begin
          r.data = pack2(mq(elem(in_data, 2*i)), mq(elem(in_data, 2*i + 1)));
          r.row  = 1'(i);
          r.last = (i == 1);
          q.push_back(r);
        end
      end
    end
  end

  // Present a tile until the DUT takes it; optionally keep in_valid high afterwards
  task automatic send(input logic [4*IW-1:0] d, input bit keep);
    bit ok;
    ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [15:0] held;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Pin the model to hand-derived values
    chk("mdl_16",    64'(mq(16)),    64'(1));
    chk("mdl_-16",   64'(mq(-16)),   64'(-1));
    chk("mdl_4096",  64'(mq(4096)),  64'(127));
    chk("mdl_-4096", 64'(mq(-4096)), 64'(-128));
    chk("mdl_2032",  64'(mq(2032)),  64'(127));
`ifdef MATRIX_SERIALIZER_ROUND_EN
    chk("mdl_-24",   64'(mq(-24)),   64'(-1));
`else
    chk("mdl_-24",   64'(mq(-24)),   64'(-2));
`endif

    // 1: basic tile
    send(pack4(16, 32, 48, -16), 0);
    @(negedge clk);
    chk("t1_row0", {48'd0, out_data}, {48'd0, pack2(1, 2)});
    chk("t1_last0", {63'd0, out_last}, 64'd0);
    @(negedge clk);
    chk("t1_row1", {48'd0, out_data}, {48'd0, pack2(3, -1)});
    chk("t1_last1", {63'd0, out_last}, 64'd1);
    @(negedge clk);
    chk("t1_idle", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // 2: saturation boundaries
    send(pack4(4096, -4096, 2032, -2048), 0);
    @(negedge clk);
    chk("t2_row0", {48'd0, out_data}, {48'd0, pack2(127, -128)});
    @(negedge clk);
    chk("t2_row1", {48'd0, out_data}, {48'd0, pack2(127, -128)});
    drain();

    // 3: rounding vs floor
    send(pack4(24, -24, 8, -8), 0);
    @(negedge clk);
`ifdef MATRIX_SERIALIZER_ROUND_EN
    chk("t3_row0", {48'd0, out_data}, {48'd0, pack2(2, -1)});
    @(negedge clk);
    chk("t3_row1", {48'd0, out_data}, {48'd0, pack2(1, 0)});
`else
    chk("t3_row0", {48'd0, out_data}, {48'd0, pack2(1, -2)});
    @(negedge clk);
    chk("t3_row1", {48'd0, out_data}, {48'd0, pack2(0, -1)});
`endif
    drain();

    // 4: backpressure on row 0
    out_ready = 1'b0;
    send(pack4(160, -32, 64, 96), 0);
    @(negedge clk);
    held = out_data;
    chk("t4_row0_val", {48'd0, held}, {48'd0, pack2(10, -2)});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data",  {48'd0, out_data}, {48'd0, held});
      chk("t4_hold_row",   {63'd0, out_row},  64'd0);
      chk("t4_hold_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_resume_row",  {63'd0, out_row},  64'd1);
    chk("t4_resume_data", {48'd0, out_data}, {48'd0, pack2(4, 6)});
    drain();

    // 5: two tiles back to back, in_valid held
    send(pack4(16, 16, 32, 32), 1);
    in_data = pack4(-32, -48, 64, 80);
    @(negedge clk);
    chk("t5_b0_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_b0_ready", {63'd0, in_ready},  64'd0);
    @(negedge clk);
    chk("t5_b1_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_b1_ready", {63'd0, in_ready},  64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("t5_b2_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_b2_data",  {48'd0, out_data},  {48'd0, pack2(-2, -3)});
    chk("t5_b2_row",   {63'd0, out_row},   64'd0);
    @(negedge clk);
    chk("t5_b3_valid", {63'd0, out_valid}, 64'd1);
    chk("t5_b3_ready", {63'd0, in_ready},  64'd1);
    chk("t5_b3_data",  {48'd0, out_data},  {48'd0, pack2(4, 5)});
    drain();

    // 6: reset in the middle of a tile
    send(pack4(48, 48, 48, 48), 0);
    #2 rst = 1'b0;
    #1 chk("t6_async_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    send(pack4(80, -80, 0, 0), 0);
    @(negedge clk);
    chk("t6_new_row",  {63'd0, out_row},  64'd0);
    chk("t6_new_data", {48'd0, out_data}, {48'd0, pack2(5, -5)});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
